// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Registered ALU with status flags, valid/ready handshakes on both
//             sides and a multi-cycle shift-add multiplier. Single-cycle ops
//             complete with one cycle of latency. MUL takes WIDTH+1 cycles.
//  Ports    : clk, rst_n         - clock, async active-low reset
//             in_valid/in_ready  - upstream handshake (a, b, sel)
//             out_valid/out_ready- downstream handshake (c + flags)
//             c, zero, neg, ovf, carry - registered result and status flags
//  Revision : 1.0 - initial registered, handshaked release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             carry
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SRA = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b1011;
    localparam logic [3:0] OP_SLT = 4'b1100;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    logic [0:0]       state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q,         c_d;
    logic             zero_q,      zero_d;
    logic             neg_q,       neg_d;
    logic             ovf_q,       ovf_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0] mplier_q,    mplier_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [SHW-1:0]   count_q,     count_d;

    logic                    w_accept;
    logic [SHW-1:0]          w_shamt;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH-1:0]        w_res;
    logic                    w_ovf;
    logic                    w_carry;
    logic [WIDTH-1:0]        w_acc_nxt;

    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;

    // Single-cycle datapath
    always_comb begin
        w_shamt = a[SHW-1:0];
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = {1'b0, a} - {1'b0, b};
        w_b_s   = b;
        w_res   = '1;
        w_ovf   = 1'b0;
        w_carry = 1'b0;
        case (sel)
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_ovf   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
                w_carry = w_sum[WIDTH];
            end
            OP_SRA: w_res = w_b_s >>> w_shamt;
            OP_SRL: w_res = b >> w_shamt;
            OP_NOR: w_res = ~(a | b);
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_ovf   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
                // No borrow out of the extended subtraction means a >= b unsigned.
                w_carry = !w_diff[WIDTH];
            end
            OP_XOR: w_res = a ^ b;
            OP_SLL: w_res = b << w_shamt;
            OP_SLT: w_res = ($signed(a) < $signed(b)) ? '1 : '0;
            default: w_res = '1;
        endcase
    end

    assign w_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        count_d     = count_q;

        // Retire the current result; a same-edge accept below may re-assert.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (sel == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = S_MUL;
                    end else begin
                        c_d         = w_res;
                        zero_d      = (w_res == '0);
                        neg_d       = w_res[MSB];
                        ovf_d       = w_ovf;
                        carry_d     = w_carry;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = w_acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_ONE;
                // The final iteration publishes its own sum on the same edge.
                if (count_q == CNT_LAST) begin
                    c_d         = w_acc_nxt;
                    zero_d      = (w_acc_nxt == '0);
                    neg_d       = w_acc_nxt[MSB];
                    ovf_d       = 1'b0;
                    carry_d     = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign carry     = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe (WIDTH=8). Accepted operations
//             push a reference-model result into a queue; a monitor pops and
//             compares each result the DUT hands over.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] c;
        logic       zero;
        logic       neg;
        logic       ovf;
        logic       carry;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       carry;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   ux, uy, sx, sy, r, amt;
        ux  = int'(x);
        uy  = int'(y);
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        amt = ux % 8;
        e   = '0;
        case (op)
            4'd0:  r = ux & uy;
            4'd1:  r = ux | uy;
            4'd2: begin
                r       = ux + uy;
                e.carry = (r > 255);
                e.ovf   = ((sx + sy) > 127) || ((sx + sy) < -128);
            end
            4'd3:  r = sy >>> amt;
            4'd4:  r = uy >> amt;
            4'd5:  r = ~(ux | uy);
            4'd6: begin
                r       = ux - uy;
                e.carry = (ux >= uy);
                e.ovf   = ((sx - sy) > 127) || ((sx - sy) < -128);
            end
            4'd8:  r = (ux * uy) % 256;
            4'd9:  r = ux ^ uy;
            4'd11: r = uy << amt;
            4'd12: r = (sx < sy) ? 255 : 0;
            default: r = 255;
        endcase
        e.c    = r[7:0];
        e.zero = (e.c == 8'h00);
        e.neg  = e.c[7];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Present one operation (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                         input bit rnd_ready);
        bit done;
        int tries;
        done     = 1'b0;
        tries    = 0;
        sel      = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        while (!done) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(op, x, y));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries >= 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: op %0h not accepted within %0d cycles", op, tries);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        sel      = 4'($urandom);
    endtask

    // Monitor: every handed-over result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got c=%0h, expected no output", c);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({c, zero, neg, ovf, carry} !== e) begin
                    n_fail++;
                    $display("FAIL result: got c=%0h z=%0b n=%0b v=%0b cy=%0b, expected c=%0h z=%0b n=%0b v=%0b cy=%0b",
                             c, zero, neg, ovf, carry, e.c, e.zero, e.neg, e.ovf, e.carry);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        sel       = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c",         32'(c),         32'd0);
        check("rst_flags",     32'({zero, neg, ovf, carry}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Directed single-cycle ops (monitor checks values; latency checked here)
        issue(4'b0010, 8'h7F, 8'h01, 1'b0);
        check("add_latency", 32'(out_valid), 32'd1);
        check("add_c",       32'(c),         32'h80);
        check("add_flags",   32'({zero, neg, ovf, carry}), 32'b0110);
        issue(4'b0110, 8'h05, 8'h05, 1'b0);
        check("sub_flags",   32'({zero, neg, ovf, carry}), 32'b1001);
        issue(4'b1100, 8'hFF, 8'h01, 1'b0);
        issue(4'b0011, 8'h0A, 8'h80, 1'b0);
        issue(4'b0100, 8'h0A, 8'h80, 1'b0);
        issue(4'b1011, 8'h03, 8'h11, 1'b0);
        check("sll_c", 32'(c), 32'h88);

        // MUL: busy for 8 cycles, a competing op must be ignored
        issue(4'b1000, 8'h0D, 8'h0B, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            sel      = 4'b0000;
            a        = 8'hFF;
            b        = 8'hFF;
            check("mul_busy_ready", 32'(in_ready),  32'd0);
            check("mul_busy_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("mul_done_valid", 32'(out_valid), 32'd1);
        check("mul_c",          32'(c),         32'h8F);
        @(posedge clk);
        #1;

        // Back-pressure hold, then release with XOR pending
        out_ready = 1'b0;
        issue(4'b0000, 8'h0F, 8'hFF, 1'b0);
        sel      = 4'b1001;
        a        = 8'h3C;
        b        = 8'h0F;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("hold_c",     32'(c),         32'h0F);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(in_ready), 32'd1);
        issue(4'b1001, 8'h3C, 8'h0F, 1'b0);
        check("xor_no_bubble_valid", 32'(out_valid), 32'd1);
        check("xor_no_bubble_c",     32'(c),         32'h33);

        // Reset in the 4th MUL cycle aborts without a result
        issue(4'b1000, 8'h37, 8'h5B, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_c",     32'(c),         32'd0);
        check("abort_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(4'b0010, 8'h02, 8'h03, 1'b0);
        check("post_reset_valid", 32'(out_valid), 32'd1);
        check("post_reset_c",     32'(c),         32'h05);

        // Randomised traffic with random back-pressure
        for (int n = 0; n < 300; n++) begin
            issue(4'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end

        // Drain
        out_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
